// File: rtl/dco_shadowed.sv
// dco_shadowed: fully registered digitally controlled oscillator.
// Divides clk into a period of maxVal+1 cycles with a high time of duty
// cycles. Period/duty are shadowed and only take effect at period
// boundaries, so a write mid-period never truncates or stretches it.
// Optional feature: define DCO_ONESHOT_EN to add the oneShot input, which
// stops the oscillator after a single period per en assertion.
module dco_shadowed #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] maxVal,
  input  logic [W-1:0] duty,
`ifdef DCO_ONESHOT_EN
  input  logic         oneShot,
`endif
  output logic         osc,
  output logic         sop,
  output logic [W-1:0] phase,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] phase_q, phase_d;
  logic [W-1:0] per_q,   per_d;
  logic [W-1:0] duty_q,  duty_d;
  logic         osc_q,   osc_d;
  logic         sop_q,   sop_d;
  logic         busy_q,  busy_d;

  // phase+1 kept one bit wider so the high-time compare never aliases at wrap
  logic [W:0]   phase_inc;
  logic         wrap;
  logic         one_shot;

  assign phase_inc = {1'b0, phase_q} + (W+1)'(1);
  assign wrap      = (phase_q == per_q);

`ifdef DCO_ONESHOT_EN
  assign one_shot = oneShot;
`else
  assign one_shot = 1'b0;
`endif

  // State register: every output is taken straight from these flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      per_q   <= '0;
      duty_q  <= '0;
      osc_q   <= 1'b0;
      sop_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      per_q   <= per_d;
      duty_q  <= duty_d;
      osc_q   <= osc_d;
      sop_q   <= sop_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    phase_d = '0;
    per_d   = per_q;
    duty_d  = duty_q;
    osc_d   = 1'b0;
    sop_d   = 1'b0;
    busy_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // shadows track the inputs while stopped
        per_d  = maxVal;
        duty_d = duty;
        if (en) begin
          state_d = RUN;
          sop_d   = 1'b1;
          osc_d   = (duty != '0);
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        if (!en) begin
          // abort immediately, no attempt to finish the period
          state_d = IDLE;
        end else if (wrap) begin
          // settings present on the wrap edge are the ones that take effect
          per_d  = maxVal;
          duty_d = duty;
          if (one_shot) begin
            state_d = DONE;
          end else begin
            sop_d  = 1'b1;
            osc_d  = (duty != '0);
            busy_d = 1'b1;
          end
        end else begin
          phase_d = phase_inc[W-1:0];
          osc_d   = (phase_inc < {1'b0, duty_q});
          busy_d  = 1'b1;
        end
      end

      DONE: begin
        per_d  = maxVal;
        duty_d = duty;
        if (!en) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign osc   = osc_q;
  assign sop   = sop_q;
  assign phase = phase_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_dco_shadowed.sv
// Scoreboard bench for dco_shadowed: directed vectors push the expected
// post-edge outputs; a monitor pops and compares after every rising edge.
module tb_dco_shadowed;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [7:0] maxVal = '0;
  logic [7:0] duty = '0;
  logic       oneShot = 1'b0;
  logic       osc, sop, busy;
  logic [7:0] phase;

  dco_shadowed #(.W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .maxVal (maxVal),
    .duty   (duty),
`ifdef DCO_ONESHOT_EN
    .oneShot(oneShot),
`endif
    .osc    (osc),
    .sop    (sop),
    .phase  (phase),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ph;
    logic       o;
    logic       s;
    logic       b;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   vec_id = 0;

  task automatic check(input string name, input exp_t got, input exp_t req);
    n_vec++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got ph=%0d osc=%b sop=%b busy=%b required ph=%0d osc=%b sop=%b busy=%b",
               name, got.ph, got.o, got.s, got.b, req.ph, req.o, req.s, req.b);
    end
  endtask

  // Monitor: the DUT presents a new output every cycle
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t req;
      req = q.pop_front();
      check($sformatf("vec%0d", vec_id), '{phase, osc, sop, busy}, req);
      vec_id++;
    end
  end

  // One edge of stimulus plus the outputs required just after that edge
  task automatic step(input logic e, input logic [7:0] mv, input logic [7:0] d,
                      input logic [7:0] ph, input logic o, input logic s, input logic b);
    @(negedge clk);
    en = e; maxVal = mv; duty = d;
    q.push_back('{ph, o, s, b});
    @(posedge clk);
  endtask

  // Whole periods with constant settings, starting on a wrap (or start) edge
  task automatic period(input int mv, input int d, input int nper);
    for (int p = 0; p < nper; p++)
      for (int i = 0; i <= mv; i++)
        step(1'b1, mv[7:0], d[7:0], i[7:0], i < d, i == 0, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // asynchronous reset, checked away from any clock edge
    #3 reset = 1'b1;
    #1 check("reset_async", '{phase, osc, sop, busy}, '{8'd0, 1'b0, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    step(0, 4, 2, 0, 0, 0, 0);                 // idle hold
    // maxVal=4 duty=2: phase 0..4, osc 11000, sop 10000
    step(1, 4, 2, 0, 1, 1, 1);
    step(1, 4, 2, 1, 1, 0, 1);
    step(1, 4, 2, 2, 0, 0, 1);
    step(1, 4, 2, 3, 0, 0, 1);
    step(1, 4, 2, 4, 0, 0, 1);
    step(1, 4, 2, 0, 1, 1, 1);
    step(1, 4, 2, 1, 1, 0, 1);
    // change to maxVal=2 duty=1 at phase 1: current period still 5 long
    step(1, 2, 1, 2, 0, 0, 1);
    step(1, 2, 1, 3, 0, 0, 1);
    step(1, 2, 1, 4, 0, 0, 1);
    step(1, 2, 1, 0, 1, 1, 1);
    step(1, 2, 1, 1, 0, 0, 1);
    step(1, 2, 1, 2, 0, 0, 1);
    step(1, 2, 1, 0, 1, 1, 1);
    // maxVal=3 duty=7 written mid-period, takes effect at next wrap
    step(1, 3, 7, 1, 0, 0, 1);
    step(1, 3, 7, 2, 0, 0, 1);
    period(3, 7, 2);                           // osc constantly 1
    period(3, 0, 2);                           // osc constantly 0, sop still
    period(0, 1, 3);                           // P=1: sop and osc every cycle
    period(255, 128, 1);                       // 256 cycles, 128 high
    step(1, 255, 128, 0, 1, 1, 1);             // wrap 255 -> 0
    step(1, 255, 128, 1, 1, 0, 1);
    step(1, 255, 128, 2, 1, 0, 1);
    step(1, 255, 128, 3, 1, 0, 1);
    // asynchronous reset mid-period at phase 3
    #3 reset = 1'b1;
    #1 check("reset_midperiod", '{phase, osc, sop, busy}, '{8'd0, 1'b0, 1'b0, 1'b0});
    en = 1'b0;
    @(negedge clk) reset = 1'b0;
    step(0, 4, 2, 0, 0, 0, 0);
    step(1, 4, 2, 0, 1, 1, 1);                 // fresh period
    step(1, 4, 2, 1, 1, 0, 1);
    step(1, 4, 2, 2, 0, 0, 1);
    step(0, 4, 2, 0, 0, 0, 0);                 // en drop aborts at once
    step(0, 4, 2, 0, 0, 0, 0);

`ifdef DCO_ONESHOT_EN
    oneShot = 1'b1;
    step(1, 2, 1, 0, 1, 1, 1);
    step(1, 2, 1, 1, 0, 0, 1);
    step(1, 2, 1, 2, 0, 0, 1);
    step(1, 2, 1, 0, 0, 0, 0);                 // DONE
    step(1, 2, 1, 0, 0, 0, 0);
    step(1, 2, 1, 0, 0, 0, 0);
    step(0, 2, 1, 0, 0, 0, 0);                 // back to IDLE
    step(1, 2, 1, 0, 1, 1, 1);
    step(1, 2, 1, 1, 0, 0, 1);
    step(1, 2, 1, 2, 0, 0, 1);
    step(1, 2, 1, 0, 0, 0, 0);
    step(1, 2, 1, 0, 0, 0, 0);
    oneShot = 1'b0;
`endif

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain got %0d pending required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dco_shadowed.md
Name: dco_shadowed

Overview:
Parametrised, fully registered digitally controlled oscillator (DCO). It divides `clk` into a programmable period with a programmable high time, producing a glitch-free `osc` plus a start-of-period strobe. Period and duty settings are shadow-loaded only at period boundaries, so mid-period writes never truncate or stretch a running period. It sits beside the neuron resonator logic as the tunable oscillation source and drives pulse dampers and delay cells downstream.

Parameters:
- W, 8, width of the period/duty settings and of the phase counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  run enable, sampled on `clk`.
- maxVal  input  W  period setting; period P = maxVal+1 clk cycles.
- duty  input  W  high-time setting in clk cycles.
- osc  output  1  registered oscillator output.
- sop  output  1  registered start-of-period strobe, 1 cycle wide.
- phase  output  W  current position in period, 0..P-1.
- busy  output  1  high while FSM is in RUN.

Behaviour:
- Reset (async, active-high): FSM=IDLE, phase=0, perS=0, dutyS=0, osc=0, sop=0, busy=0. Outputs go to these values immediately, not at the next edge.
- `osc` is never combinationally derived from `clk`; all outputs come straight from flops.
- Shadow registers perS and dutyS:
  - In IDLE/DONE, loaded from `maxVal`/`duty` every cycle.
  - In RUN, loaded only on the edge that starts a new period.
- FSM states: IDLE, RUN, DONE (DONE is reachable only with the optional feature).
- IDLE, edge with en=1:
  - Go to RUN; phase<=0; perS<=maxVal; dutyS<=duty.
  - sop<=1; osc<=(duty>0); busy<=1.
  - First period therefore begins one edge after `en` is sampled high.
- IDLE, edge with en=0: hold; phase=0, osc=0, sop=0.
- RUN, edge with en=1 and phase!=perS:
  - phase<=phase+1; sop<=0; osc<=((phase+1)<dutyS).
- RUN, edge with en=1 and phase==perS (wrap):
  - phase<=0; perS<=maxVal; dutyS<=duty.
  - sop<=1; osc<=(duty>0).
- RUN, edge with en=0: go to IDLE; phase<=0, osc<=0, sop<=0, busy<=0. The period is aborted immediately, not finished.
- Resulting waveform: in the cycle with phase=i, osc=1 iff i<dutyS.
  - High time = min(dutyS, perS+1) cycles.
  - duty=0: osc constantly 0, while sop still pulses.
  - duty>=P: osc constantly 1 while busy.
- maxVal=0: P=1; phase stays 0; sop=1 every cycle; osc=1 iff dutyS>=1.
- maxVal=2^W-1: P=2^W; phase wraps from all-ones to 0 with no overflow flag.
- Comparisons are unsigned W-bit. phase+1 is computed in W+1 bits, so there is no false match at wrap.
- Simultaneous settings change and wrap: the values present on the wrap edge are the ones loaded.
- Reset asserted mid-period: immediate return to reset values. After reset release, the next edge with en=1 starts a fresh period at phase 0.

Optional Feature:
- Macro DCO_ONESHOT_EN.
- Defined:
  - Adds input port `oneShot` (1 bit).
  - When oneShot=1 on a RUN wrap edge, the FSM goes to DONE instead of starting a new period: phase<=0, osc<=0, sop<=0, busy<=0.
  - DONE holds until an edge with en=0, which returns the FSM to IDLE. This gives exactly one period per `en` assertion.
  - oneShot is sampled only at wrap edges.
- Not defined: no `oneShot` port; DONE is never entered; the block runs continuously while en=1.

Test Plan:
- W=8, maxVal=4, duty=2, en rises and stays high → from the first edge after en sampled: phase 0,1,2,3,4 repeating; osc 1,1,0,0,0; sop 1,0,0,0,0; busy=1.
- Same setup, change maxVal to 2 and duty to 1 while phase=1 → the current period still lasts 5 cycles with osc 1,1,0,0,0; the next period is 3 cycles with osc 1,0,0.
- maxVal=3, duty=7 → osc constantly 1, sop every 4th cycle. Then duty=0 → from the next period, osc constantly 0 and sop still every 4th cycle.
- maxVal=0, duty=1 → sop=1 and osc=1 every cycle, phase=0. Then maxVal=255, duty=128 → 256-cycle period, 128 high, phase wraps 255→0.
- Assert reset asynchronously at phase=3 mid-period → osc, sop, busy and phase go to 0 before the next clk edge. After release with en=1 → fresh period from phase 0 with sop=1.
- With DCO_ONESHOT_EN: oneShot=1, maxVal=2, duty=1, en held high → exactly one period (osc 1,0,0; sop 1,0,0), then busy=0 and osc=0 while en stays high. Drop en for 1 cycle and re-raise → exactly one more period.
